// File: rtl/fa_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package fa_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Legal when STAGES splits WIDTH into equal, non-empty chunks.
  function automatic bit stages_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/fa_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB for overflow.
module fa_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = ci_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (carry[i]),
      .s_o  (s_o[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_o    = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];

endmodule

// File: rtl/fa_pipe_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES registered chunks with a
// valid/ready handshake between stages; stalls collapse bubbles, no skid buffering.
module fa_pipe_addsub
  import fa_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("fa_pipe_addsub: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  // Per-stage registers: x holds resolved sum bits below the chunk and raw a bits above it.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] x_q   [STAGES];
  logic [WIDTH-1:0] bn_q  [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] x_in  [STAGES];
  logic [WIDTH-1:0] bn_in [STAGES];
  logic             cin   [STAGES];
  logic             vin   [STAGES];
  logic [WIDTH-1:0] x_d   [STAGES];
  logic [CHUNK-1:0] sum_c [STAGES];
  logic             co_c  [STAGES];
  logic             c_msb [STAGES];
  logic             rdy   [STAGES+1];

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Mode is folded in here so every later stage is a plain adder.
  always_comb begin
    b_eff = b;
    c_eff = ci;
    unique case (sub)
      MODE_ADD: begin
        b_eff = b;
        c_eff = ci;
      end
      MODE_SUB: begin
        b_eff = ~b;
        c_eff = ~ci;
      end
    endcase
  end

  always_comb begin
    x_in[0]  = a;
    bn_in[0] = b_eff;
    cin[0]   = c_eff;
    vin[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k]  = x_q[k-1];
      bn_in[k] = bn_q[k-1];
      cin[k]   = c_q[k-1];
      vin[k]   = vld_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fa_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a_i     (x_in[k][k*CHUNK +: CHUNK]),
      .b_i     (bn_in[k][k*CHUNK +: CHUNK]),
      .ci_i    (cin[k]),
      .s_o     (sum_c[k]),
      .co_o    (co_c[k]),
      .c_msb_o (c_msb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      x_d[k] = x_in[k];
      x_d[k][k*CHUNK +: CHUNK] = sum_c[k];
    end
  end

  // rdy[k] is the advance condition of stage k; an empty stage always accepts.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        x_q[k]   <= '0;
        bn_q[k]  <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vin[k];
          if (vin[k]) begin
            x_q[k]  <= x_d[k];
            bn_q[k] <= bn_in[k];
            c_q[k]  <= co_c[k];
          end
        end
      end
      if (rdy[STAGES-1] && vin[STAGES-1]) begin
        ovf_q <= co_c[STAGES-1] ^ c_msb[STAGES-1];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES-1];
  assign s         = x_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
